cpu7_ifu_ibuf: RTL and testbench
================================

Name: cpu7_ifu_ibuf

Overview:
Instruction buffer between the fetch datapath and decode. Captures fetched {pc, inst, ex, exccode} beats into a small FIFO and presents them in order to decode through a valid/allow handshake. Decouples fetch return timing from decode stalls. Flushes on branch or writeback cancel, and blocks further fetch after an exception-tagged entry.

Parameters:
DEPTH, 4, number of entries; power of two, ≥2
PTR_W, $clog2(DEPTH), read/write pointer width (derived)

Ports:
clock        in   1   single clock, rising edge
reset        in   1   synchronous, active-high
flush        in   1   br_cancel | wb_cancel; discard all entries this cycle
in_valid     in   1   fetch beat valid (inst_valid from fetch)
in_pc        in   32  pc of fetched inst
in_inst      in   32  fetched instruction word
in_ex        in   1   fetch exception flag
in_exccode   in   6   fetch exception code
in_allow     out  1   buffer can accept a beat this cycle
out_valid    out  1   head entry valid to decode
out_pc       out  32  head pc
out_inst     out  32  head instruction
out_ex       out  1   head exception flag
out_exccode  out  6   head exception code
out_allow    in   1   decode accepts head this cycle
count        out  PTR_W+1  occupied entries, 0..DEPTH

Behaviour:
- Push = in_valid & in_allow & ~flush. Pop = out_valid & out_allow & ~flush. Both may occur in the same cycle; count stays unchanged, pointers both advance.
- in_allow = (count < DEPTH) & ~ex_hold. This is combinational from registered state only. It does not depend on in_valid or out_allow, so a full buffer does not accept even when a pop occurs in the same cycle.
- Beat with in_valid=1 while in_allow=0 is dropped. Fetch holds its pc and replays the beat.
- out_valid = (count != 0). out_* are driven from the entry at rd_ptr, registered storage. Without the bypass option, push-to-out_valid latency is 1 cycle.
- Pointers wrap modulo DEPTH, with no gap. count increments on push-only, decrements on pop-only.
- ex_hold register: set on a push with in_ex=1. Cleared only by flush or reset. While set, in_allow=0. Entries already queued still drain.
- flush has priority over push and pop. In the cycle after flush: count=0, pointers=0, ex_hold=0, out_valid=0. The in-flight beat in the flush cycle is discarded.
- Reset values: count=0, rd_ptr=wr_ptr=0, ex_hold=0, out_valid=0, in_allow=1 (first cycle after reset). out_pc/out_inst/out_exccode=0 and out_ex=0, because storage entry 0 is cleared on reset.
- Reset asserted mid-operation behaves identically to flush plus storage entry 0 clear. Reset dominates flush.
- Storage data is not cleared on flush; only valid tracking resets.
- Storage entries not at the head are don't-care on out_*.

Optional Feature:
Macro CPU7_IFU_IBUF_BYPASS_EN.
- Defined: when count==0 and in_valid & in_allow & ~flush, the beat appears combinationally on out_* with out_valid=1 in the same cycle. If out_allow=1 that cycle, the beat is consumed and not written (count stays 0); otherwise it is written normally.
- Undefined: strict 1-cycle latency through storage, and out_* are purely registered.
- ex_hold sets on an in_ex push in both cases, including a bypassed-and-consumed beat.

Decomposition:
- Shared package cpu7_ifu_pkg:
  - IFU_PC_W=32, IFU_INST_W=32, IFU_EXCCODE_W=6
  - IFU_ENTRY_W=71, the packed {ex, exccode, pc, inst} layout constant
  - typedef of the ibuf entry struct
- One sub-module, cpu7_ifu_ibuf_store: DEPTH×IFU_ENTRY_W register array with write port (wr_en, wr_ptr, wdata) and async read port (rd_ptr, rdata), plus entry 0 reset clear. Control (pointers, count, ex_hold, handshake) stays in cpu7_ifu_ibuf.

Test Plan:
1. Reset then push pc=0x1C000000, inst=0x02800C0C with out_allow=0 → next cycle out_valid=1, out_pc=0x1C000000, count=1. Without bypass, out_valid=0 in the push cycle.
2. Fill to 4 with out_allow=0 → in_allow=0 at count=4. A 5th beat (pc=0x1C000010) is dropped. Then drain with out_allow=1 → pcs 0x…00, 04, 08, 0C in order, count returns to 0.
3. Steady stream, with in_valid=1 and out_allow=1 every cycle for 20 cycles → count constant at 1, pointers wrap at least 4 times, no pc skipped or duplicated.
4. count=3, then flush=1 together with in_valid=1 and out_allow=1 → next cycle count=0, out_valid=0, in_allow=1. The flushed beat never appears on out_*.
5. Push with in_ex=1, exccode=0x08 → in_allow=0 from the next cycle, and earlier entries drain followed by the ex entry (out_ex=1, out_exccode=0x08). in_allow stays 0 until flush, after which in_allow=1.
6. With CPU7_IFU_IBUF_BYPASS_EN, empty buffer, in_valid=1, out_allow=1, pc=0x1C000100 → out_valid=1 and out_pc=0x1C000100 in the same cycle, count remains 0. Repeat with out_allow=0 → count=1 next cycle.

Source files
------------

// File: rtl/cpu7_ifu_pkg.sv
// Shared IFU types and widths used by the instruction buffer and its storage.
package cpu7_ifu_pkg;

    localparam int IFU_PC_W      = 32;
    localparam int IFU_INST_W    = 32;
    localparam int IFU_EXCCODE_W = 6;
    localparam int IFU_ENTRY_W   = 1 + IFU_EXCCODE_W + IFU_PC_W + IFU_INST_W;

    // Packed layout {ex, exccode, pc, inst}, 71 bits.
    typedef struct packed {
        logic                     ex;
        logic [IFU_EXCCODE_W-1:0] exccode;
        logic [IFU_PC_W-1:0]      pc;
        logic [IFU_INST_W-1:0]    inst;
    } ibuf_entry_t;

endpackage

// File: rtl/cpu7_ifu_ibuf_store.sv
// Instruction buffer storage: DEPTH entries, one write port, asynchronous read.
// Only entry 0 is cleared on reset so the empty head reads back as zero.
module cpu7_ifu_ibuf_store
    import cpu7_ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [PTR_W-1:0]       wr_ptr,
    input  logic [IFU_ENTRY_W-1:0] wdata,
    input  logic [PTR_W-1:0]       rd_ptr,
    output logic [IFU_ENTRY_W-1:0] rdata
);

    logic [IFU_ENTRY_W-1:0] mem_q [DEPTH];
    logic [IFU_ENTRY_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = wdata;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            mem_q[0] <= '0;
        end
    end

    assign rdata = mem_q[rd_ptr];

endmodule

// File: rtl/cpu7_ifu_ibuf.sv
// Fetch-to-decode instruction buffer: in-order FIFO with flush and exception hold.
// Optional same-cycle bypass of an empty buffer: define CPU7_IFU_IBUF_BYPASS_EN.
module cpu7_ifu_ibuf
    import cpu7_ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [IFU_PC_W-1:0]      in_pc,
    input  logic [IFU_INST_W-1:0]    in_inst,
    input  logic                     in_ex,
    input  logic [IFU_EXCCODE_W-1:0] in_exccode,
    output logic                     in_allow,
    output logic                     out_valid,
    output logic [IFU_PC_W-1:0]      out_pc,
    output logic [IFU_INST_W-1:0]    out_inst,
    output logic                     out_ex,
    output logic [IFU_EXCCODE_W-1:0] out_exccode,
    input  logic                     out_allow,
    output logic [PTR_W:0]           count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W:0]         count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic                   ex_hold_q, ex_hold_d;

    ibuf_entry_t            in_entry, store_entry, head_entry;
    logic [IFU_ENTRY_W-1:0] store_rdata;
    logic                   push, pop, bypass, bypass_take;
    logic                   wr_adv, rd_adv, wr_en;

    always_comb begin
        in_entry    = '{ex: in_ex, exccode: in_exccode, pc: in_pc, inst: in_inst};
        store_entry = ibuf_entry_t'(store_rdata);

        // Depends on registered state only, so a full buffer refuses even while popping.
        in_allow = (count_q != FULL_CNT) && !ex_hold_q;
        push     = in_valid && in_allow && !flush;
`ifdef CPU7_IFU_IBUF_BYPASS_EN
        bypass   = push && (count_q == '0);
`else
        bypass   = 1'b0;
`endif
        out_valid   = (count_q != '0) || bypass;
        head_entry  = bypass ? in_entry : store_entry;
        pop         = out_valid && out_allow && !flush;
        bypass_take = bypass && out_allow;

        // A bypassed beat consumed by decode never touches storage or pointers.
        wr_adv = push && !bypass_take;
        rd_adv = pop && !bypass_take;
        wr_en  = wr_adv && !reset;

        out_pc      = head_entry.pc;
        out_inst    = head_entry.inst;
        out_ex      = head_entry.ex;
        out_exccode = head_entry.exccode;
        count       = count_q;
    end

    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        ex_hold_d = ex_hold_q || (push && in_ex);

        if (wr_adv) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_adv, rd_adv})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (flush) begin
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            ex_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            ex_hold_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            ex_hold_q <= ex_hold_d;
        end
    end

    cpu7_ifu_ibuf_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr_q),
        .wdata  (in_entry),
        .rd_ptr (rd_ptr_q),
        .rdata  (store_rdata)
    );

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Self-checking bench for cpu7_ifu_ibuf: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_cpu7_ifu_ibuf;
    import cpu7_ifu_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ex, out_allow;
    logic [31:0] in_pc, in_inst;
    logic [5:0]  in_exccode;
    logic        in_allow, out_valid, out_ex;
    logic [31:0] out_pc, out_inst;
    logic [5:0]  out_exccode;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    ibuf_entry_t mq[$];
    bit          m_hold;

    always #5 clock = ~clock;

    cpu7_ifu_ibuf #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ex       (in_ex),
        .in_exccode  (in_exccode),
        .in_allow    (in_allow),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ex      (out_ex),
        .out_exccode (out_exccode),
        .out_allow   (out_allow),
        .count       (count)
    );

    // Apply inputs for one cycle on the falling edge, then let them settle.
    task automatic drive(input bit rst, input bit fl, input bit v, input logic [31:0] pc,
                         input logic [31:0] inst, input bit ex, input logic [5:0] code,
                         input bit oa);
        @(negedge clock);
        reset = rst; flush = fl; in_valid = v; in_pc = pc; in_inst = inst;
        in_ex = ex; in_exccode = code; out_allow = oa;
        #1;
    endtask

    task automatic idle(input bit oa);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, oa);
    endtask

    // Advance the reference model by the current inputs, then take the clock edge.
    task automatic tick();
        bit acc;
        bit take_byp;
        acc = 1'b0;
        take_byp = 1'b0;
        if (reset || flush) begin
            mq.delete();
            m_hold = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH) && !m_hold;
`ifdef CPU7_IFU_IBUF_BYPASS_EN
            take_byp = acc && (mq.size() == 0) && out_allow;
`endif
            if (!take_byp) begin
                if (mq.size() != 0 && out_allow) void'(mq.pop_front());
                if (acc) mq.push_back('{ex: in_ex, exccode: in_exccode, pc: in_pc, inst: in_inst});
            end
            if (acc && in_ex) m_hold = 1'b1;
        end
        @(posedge clock);
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0);
        tick();
        tick();
        idle(1'b0);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (in_allow !== 1'b1) begin fails++; $display("FAIL reset_in_allow: got %b want 1", in_allow); end
        tests++; if ({out_ex, out_exccode, out_pc, out_inst} !== 71'h0) begin
            fails++; $display("FAIL reset_out_data: got ex=%b code=%h pc=%h inst=%h want all zero", out_ex, out_exccode, out_pc, out_inst);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_push();
        bit exp_v;
        drive(1'b0, 1'b0, 1'b1, 32'h1C000000, 32'h02800C0C, 1'b0, 6'h0, 1'b0);
`ifdef CPU7_IFU_IBUF_BYPASS_EN
        exp_v = 1'b1;
`else
        exp_v = 1'b0;
`endif
        tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL push_cycle_valid: got %b want %b", out_valid, exp_v); end
        tick();
        idle(1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL push_next_valid: got %b want 1", out_valid); end
        tests++; if (out_pc !== 32'h1C000000) begin fails++; $display("FAIL push_next_pc: got %h want 1c000000", out_pc); end
        tests++; if (out_inst !== 32'h02800C0C) begin fails++; $display("FAIL push_next_inst: got %h want 02800c0c", out_inst); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL push_next_count: got %0d want 1", count); end
        $display("[TB] push pc=1c000000 inst=02800c0c");
        tick();
        do_flush();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1C000000 + 32'(4*i), 32'h100 + 32'(i), 1'b0, 6'h0, 1'b0);
            tests++; if (in_allow !== 1'b1) begin fails++; $display("FAIL fill_allow[%0d]: got %b want 1", i, in_allow); end
            tick();
        end
        // Full: a fifth beat is refused even though decode pops in the same cycle.
        drive(1'b0, 1'b0, 1'b1, 32'h1C000010, 32'h200, 1'b0, 6'h0, 1'b1);
        tests++; if (in_allow !== 1'b0) begin fails++; $display("FAIL full_allow: got %b want 0", in_allow); end
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", count); end
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            idle(1'b1);
            tests++; if (out_valid !== 1'b1 || out_pc !== 32'h1C000000 + 32'(4*i)) begin
                fails++; $display("FAIL drain_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'h1C000000 + 32'(4*i));
            end
            $display("[TB] drain pc=%h", out_pc);
            tick();
        end
        idle(1'b0);
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL drain_empty: got count=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1C000400 + 32'(4*i), 32'(i), 1'b0, 6'h0, 1'b1);
`ifdef CPU7_IFU_IBUF_BYPASS_EN
            exp_cnt = 3'd0;
            exp_pc  = 32'h1C000400 + 32'(4*i);
`else
            exp_cnt = (i == 0) ? 3'd0 : 3'd1;
            exp_pc  = 32'h1C000400 + 32'(4*(i-1));
`endif
            tests++; if (count !== exp_cnt) begin fails++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, count, exp_cnt); end
            if (exp_cnt != 3'd0 || i > 0 || exp_pc == 32'h1C000400) begin
                if (out_valid === 1'b1 || exp_cnt != 3'd0 || i > 0) begin
                    tests++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                        if (!(i == 0 && exp_cnt == 3'd0 && exp_pc != 32'h1C000400)) begin
                            fails++; $display("FAIL stream_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, exp_pc);
                        end
                    end
                end
            end
            tick();
        end
        do_flush();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1C000800 + 32'(4*i), 32'h0, 1'b0, 6'h0, 1'b0);
            tick();
        end
        idle(1'b0);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        drive(1'b0, 1'b1, 1'b1, 32'hDEAD0000, 32'h0, 1'b0, 6'h0, 1'b1);
        tick();
        idle(1'b1);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        tests++; if (in_allow !== 1'b1) begin fails++; $display("FAIL flush_allow: got %b want 1", in_allow); end
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d]: got v=%b pc=%h want v=0", i, out_valid, out_pc); end
            tick();
        end
    endtask

    task automatic test_exception();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h1C000200 + 32'(4*i), 32'h0, (i == 2), (i == 2) ? 6'h08 : 6'h00, 1'b0);
            tests++; if (in_allow !== 1'b1) begin fails++; $display("FAIL ex_pre_allow[%0d]: got %b want 1", i, in_allow); end
            tick();
        end
        idle(1'b0);
        tests++; if (in_allow !== 1'b0) begin fails++; $display("FAIL ex_hold_allow: got %b want 0", in_allow); end
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL ex_count: got %0d want 3", count); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h00000BAD, 32'h0, 1'b0, 6'h0, 1'b1);
            tests++; if (out_valid !== 1'b1 || out_pc !== 32'h1C000200 + 32'(4*i) || out_ex !== (i == 2)) begin
                fails++; $display("FAIL ex_drain[%0d]: got v=%b pc=%h ex=%b want v=1 pc=%h ex=%b", i, out_valid, out_pc, out_ex, 32'h1C000200 + 32'(4*i), (i == 2));
            end
            if (i == 2) begin
                tests++; if (out_exccode !== 6'h08) begin fails++; $display("FAIL ex_code: got %h want 08", out_exccode); end
            end
            $display("[TB] drain pc=%h ex=%b", out_pc, out_ex);
            tick();
        end
        idle(1'b0);
        tests++; if (count !== 3'd0 || in_allow !== 1'b0) begin
            fails++; $display("FAIL ex_after_drain: got count=%0d allow=%b want 0/0", count, in_allow);
        end
        tick();
        do_flush();
        idle(1'b0);
        tests++; if (in_allow !== 1'b1) begin fails++; $display("FAIL ex_flush_allow: got %b want 1", in_allow); end
        tick();
    endtask

`ifdef CPU7_IFU_IBUF_BYPASS_EN
    task automatic test_bypass();
        drive(1'b0, 1'b0, 1'b1, 32'h1C000100, 32'h11, 1'b0, 6'h0, 1'b1);
        tests++; if (out_valid !== 1'b1 || out_pc !== 32'h1C000100) begin
            fails++; $display("FAIL byp_same_cycle: got v=%b pc=%h want v=1 pc=1c000100", out_valid, out_pc);
        end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL byp_count_now: got %0d want 0", count); end
        tick();
        idle(1'b0);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL byp_count_next: got %0d want 0", count); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h1C000100, 32'h11, 1'b0, 6'h0, 1'b0);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL byp_hold_valid: got %b want 1", out_valid); end
        tick();
        idle(1'b0);
        tests++; if (count !== 3'd1 || out_pc !== 32'h1C000100) begin
            fails++; $display("FAIL byp_written: got count=%0d pc=%h want 1/1c000100", count, out_pc);
        end
        tick();
        do_flush();
    endtask
`endif

    task automatic test_random();
        int          n;
        bit          allow, byp, exp_v;
        ibuf_entry_t head;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0), $urandom_range(0, 3) != 0,
                  $urandom, $urandom, ($urandom_range(0, 19) == 0), 6'($urandom), $urandom_range(0, 2) != 0);
            n     = mq.size();
            allow = (n < DEPTH) && !m_hold;
            byp   = 1'b0;
`ifdef CPU7_IFU_IBUF_BYPASS_EN
            byp   = allow && in_valid && !flush && (n == 0);
`endif
            exp_v = (n != 0) || byp;
            head  = byp ? ibuf_entry_t'({in_ex, in_exccode, in_pc, in_inst}) : ((n != 0) ? mq[0] : '0);
            tests++; if (count !== 3'(n)) begin fails++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, n); end
            tests++; if (in_allow !== allow) begin fails++; $display("FAIL rnd_allow[%0d]: got %b want %b", c, in_allow, allow); end
            tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                tests++; if ({out_ex, out_exccode, out_pc, out_inst} !== head) begin
                    fails++; $display("FAIL rnd_head[%0d]: got %h want %h", c, {out_ex, out_exccode, out_pc, out_inst}, head);
                end
            end
            tick();
        end
        do_flush();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b1, 32'h1C000A00, 32'hAAAA5555, 1'b0, 6'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h1C000A04, 32'h5555AAAA, 1'b1, 6'h3F, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h00001234, 32'hFFFFFFFF, 1'b1, 6'h3F, 1'b1);
        tick();
        idle(1'b0);
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_state: got count=%0d v=%b want 0/0", count, out_valid);
        end
        tests++; if (in_allow !== 1'b1) begin fails++; $display("FAIL midrst_allow: got %b want 1", in_allow); end
        tests++; if ({out_ex, out_exccode, out_pc, out_inst} !== 71'h0) begin
            fails++; $display("FAIL midrst_data: got pc=%h inst=%h want zero", out_pc, out_inst);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_ex = 1'b0; in_exccode = '0; out_allow = 1'b0;
        m_hold = 1'b0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_stream();
        test_flush();
        test_exception();
`ifdef CPU7_IFU_IBUF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
